// File: rtl/cp0_unit.sv
// Coprocessor 0 for the P7 pipeline: SR, Cause and EPC, plus exception/interrupt request generation.
// Define CP0_PRID_EN to add the read-only PRId register at address 15.
module cp0_unit #(
  parameter logic [31:0] HANDLER_PC = 32'h00004180,
  parameter logic [31:0] PRID_VALUE = 32'h20240707
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic        req,
  output logic [31:0] epc_out,
  output logic [31:0] handler_pc
);

`ifdef CP0_PRID_EN
  localparam bit PRID_EN = 1'b1;
`else
  localparam bit PRID_EN = 1'b0;
`endif

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_value;
  logic [31:0] cause_value;

  assign sr_value    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
  assign cause_value = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};

  // EXL masks both sources so a single event yields a one-cycle request.
  assign int_req = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = (exc_code != 5'd0) & ~sr_exl;
  assign req     = int_req | exc_req;

  assign handler_pc = HANDLER_PC;

  // Forward an in-flight mtc0 to EPC so a following eret sees the new return address.
  assign epc_out = (we && addr == 5'd14) ? wdata : epc;

  always_comb begin
    rdata = 32'd0;
    case (addr)
      5'd12:   rdata = sr_value;
      5'd13:   rdata = cause_value;
      5'd14:   rdata = epc;
      5'd15:   rdata = PRID_EN ? PRID_VALUE : 32'd0;
      default: rdata = 32'd0;
    endcase
  end

  // A taken request cancels the M-stage instruction, so its mtc0 and eret are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= 6'd0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc       <= 32'd0;
    end else begin
      cause_ip <= hw_int;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bd_in;
        cause_exc <= int_req ? 5'd0 : exc_code;
        epc       <= bd_in ? (vpc - 32'd4) : vpc;
      end else begin
        if (eret)
          sr_exl <= 1'b0;
        if (we) begin
          case (addr)
            5'd12: begin
              sr_im  <= wdata[15:10];
              sr_exl <= wdata[1];
              sr_ie  <= wdata[0];
            end
            5'd14:   epc <= wdata;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: driver pushes model predictions, a negedge monitor pops and compares.
module tb_cp0_unit;

  typedef struct packed {
    logic        rst;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  exc;
    logic        eret;
    logic [5:0]  hw;
  } stim_t;

  typedef struct packed {
    logic        req;
    logic [31:0] rdata;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code;
  logic        eret;
  logic [5:0]  hw_int;
  logic        req;
  logic [31:0] epc_out;
  logic [31:0] handler_pc;

  cp0_unit dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .vpc(vpc), .bd_in(bd_in), .exc_code(exc_code), .eret(eret), .hw_int(hw_int),
    .req(req), .epc_out(epc_out), .handler_pc(handler_pc)
  );

  always #5 clk = ~clk;

  // Reference state held as whole architectural register values.
  logic [31:0] m_sr, m_cause, m_epc;
  bit          model_valid = 0;
  stim_t       cur;
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic stim_t st(input logic rst, input logic w, input int a, input logic [31:0] wd,
                               input logic [31:0] pc, input logic b, input int e, input logic er,
                               input logic [5:0] h);
    stim_t s;
    s.rst = rst; s.we = w; s.addr = 5'(a); s.wdata = wd; s.vpc = pc;
    s.bd = b; s.exc = 5'(e); s.eret = er; s.hw = h;
    return s;
  endfunction

  function automatic bit model_int(input stim_t s);
    return ((s.hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic bit model_req(input stim_t s);
    return model_int(s) || (s.exc != 5'd0 && !m_sr[1]);
  endfunction

  // Advance the reference by one clock edge using the inputs that were live at that edge.
  task automatic modelEdge(input stim_t s);
    bit r, ir;
    r  = model_req(s);
    ir = model_int(s);
    if (s.rst) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
      model_valid = 1;
    end else if (model_valid) begin
      if (r) begin
        m_sr    = m_sr | 32'h2;
        m_cause = (32'(s.bd) << 31) | (32'(s.hw) << 10) | ((ir ? 32'd0 : 32'(s.exc)) << 2);
        m_epc   = s.bd ? s.vpc - 32'd4 : s.vpc;
      end else begin
        m_cause = (m_cause & ~32'h0000FC00) | (32'(s.hw) << 10);
        if (s.eret) m_sr = m_sr & ~32'h2;
        if (s.we && s.addr == 5'd12) m_sr = s.wdata & 32'h0000FC03;
        if (s.we && s.addr == 5'd14) m_epc = s.wdata;
      end
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    cur = s;
    reset = s.rst; we = s.we; addr = s.addr; wdata = s.wdata; vpc = s.vpc;
    bd_in = s.bd; exc_code = s.exc; eret = s.eret; hw_int = s.hw;
    if (model_valid) begin
      e.req = model_req(s);
      case (s.addr)
        5'd12: e.rdata = m_sr;
        5'd13: e.rdata = m_cause;
        5'd14: e.rdata = m_epc;
`ifdef CP0_PRID_EN
        5'd15: e.rdata = 32'h20240707;
`endif
        default: e.rdata = 32'd0;
      endcase
      e.epc_out    = (s.we && s.addr == 5'd14) ? s.wdata : m_epc;
      e.handler_pc = 32'h00004180;
      sb.push_back(e);
    end
  endtask

  task automatic step(input stim_t s);
    @(posedge clk);
    modelEdge(cur);
    #2;
    applyStimulus(s);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("req", 32'(req), 32'(e.req));
        checkOutput("rdata", rdata, e.rdata);
        checkOutput("epc_out", epc_out, e.epc_out);
        checkOutput("handler_pc", handler_pc, e.handler_pc);
      end
    end
  end

  initial begin : driver
    stim_t dir[$];
    stim_t s;
    applyStimulus(st(1, 0, 0, 0, 0, 0, 0, 0, 6'h00));
    dir = '{
      st(0, 0, 12, 0, 0, 0, 0, 0, 6'h00),
      st(0, 0, 13, 0, 0, 0, 0, 0, 6'h3F),
      st(0, 0, 14, 0, 0, 0, 0, 0, 6'h3F),
      st(0, 1, 12, 32'h00000401, 0, 0, 0, 0, 6'h00),
      st(0, 0, 14, 0, 32'h3010, 0, 0, 0, 6'h01),
      st(0, 0, 13, 0, 0, 0, 0, 0, 6'h01),
      st(0, 0, 12, 0, 0, 0, 0, 0, 6'h00),
      st(0, 0, 14, 0, 0, 0, 0, 0, 6'h00),
      st(0, 1, 14, 32'h3100, 0, 0, 1, 0, 6'h00),
      st(0, 0, 12, 0, 0, 0, 0, 0, 6'h00),
      st(0, 0, 13, 0, 32'h3020, 1, 10, 0, 6'h00),
      st(0, 0, 14, 0, 0, 0, 0, 0, 6'h00),
      st(0, 0, 13, 0, 0, 0, 0, 0, 6'h00),
      st(0, 0, 12, 0, 0, 0, 0, 1, 6'h00),
      st(0, 0, 13, 0, 32'h3030, 0, 4, 0, 6'h01),
      st(0, 0, 13, 0, 0, 0, 0, 0, 6'h00),
      st(0, 0, 12, 0, 0, 0, 0, 1, 6'h00),
      st(0, 1, 14, 32'h5555, 32'h3040, 0, 12, 0, 6'h00),
      st(0, 0, 14, 0, 0, 0, 0, 0, 6'h00),
      st(0, 0, 15, 0, 0, 0, 0, 0, 6'h00),
      st(1, 1, 12, 32'h0000FC03, 32'h3050, 1, 6, 1, 6'h3F),
      st(0, 0, 12, 0, 0, 0, 0, 0, 6'h00),
      st(0, 0, 14, 0, 0, 0, 0, 0, 6'h00)
    };
    foreach (dir[i]) step(dir[i]);

    for (int i = 0; i < 600; i++) begin
      s.rst   = ($urandom_range(0, 99) < 2);
      s.we    = ($urandom_range(0, 99) < 30);
      case ($urandom_range(0, 5))
        0: s.addr = 5'd12;
        1: s.addr = 5'd13;
        2: s.addr = 5'd14;
        3: s.addr = 5'd15;
        default: s.addr = 5'($urandom);
      endcase
      s.wdata = $urandom;
      s.vpc   = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 7)) : $urandom;
      s.bd    = 1'($urandom);
      s.exc   = ($urandom_range(0, 99) < 15) ? 5'($urandom) : 5'd0;
      s.eret  = ($urandom_range(0, 99) < 15);
      s.hw    = ($urandom_range(0, 99) < 30) ? 6'($urandom) : 6'd0;
      if (s.eret && s.we && s.addr == 5'd12) s.we = 1'b0;
      step(s);
    end

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
